// File: rtl/sprite_sequencer.sv
// Sprite sheet sequencer: picks the animation frame and draw position of one character,
// advancing only on rising edges of the VGA frame pulse.
module sprite_sequencer #(
   parameter int FRAME_DIV = 8,
   parameter int STEP      = 2,
   parameter int X_MIN     = 0,
   parameter int X_MAX     = 640,
   parameter int X_INIT    = 304,
   parameter int Y_INIT    = 400,
   parameter int HOP       = 8
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_clk,
   input  logic [1:0] dir,
   input  logic       act_req,
   output logic [3:0] sel,
   output logic [9:0] shape_x,
   output logic [9:0] shape_y,
   output logic       anim_busy,
   output logic [1:0] state_dbg
);

   // Encoding equals the sprite sheet row, so sel[3:2] is the state itself.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WALK_R = 2'd1,
      WALK_L = 2'd2,
      ACTION = 2'd3
   } state_t;

   localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);
   localparam logic [10:0] X_RIGHT = 11'(X_MAX - 32);
   localparam logic [10:0] X_LEFT  = 11'(X_MIN);
   localparam logic [10:0] STEP_W  = 11'(STEP);
   localparam logic [9:0]  STEP_N  = 10'(STEP);
   localparam logic [9:0]  Y_REST  = 10'(Y_INIT);
   localparam logic [9:0]  Y_HOP   = 10'(Y_INIT - HOP);

   state_t           state, state_next, target;
   logic             frame_clk_d, tick_arm, tick;
   logic             act_pend, act_pend_next;
   logic [DIV_W-1:0] div, div_next;
   logic [3:0]       sel_next;
   logic [9:0]       x_next, y_next;
   logic [10:0]      x_wide, x_inc;
   logic             busy_next;

   // tick_arm blocks the first cycle after reset release, so a frame_clk that is
   // already high (or rises right at release) does not count as an edge.
   assign tick      = frame_clk & ~frame_clk_d & tick_arm;
   assign x_wide    = {1'b0, shape_x};
   assign x_inc     = x_wide + STEP_W;
   assign state_dbg = state;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= IDLE;
         sel         <= 4'd0;
         shape_x     <= 10'(X_INIT);
         shape_y     <= Y_REST;
         anim_busy   <= 1'b0;
         div         <= '0;
         act_pend    <= 1'b0;
         frame_clk_d <= 1'b0;
         tick_arm    <= 1'b0;
      end else begin
         state       <= state_next;
         sel         <= sel_next;
         shape_x     <= x_next;
         shape_y     <= y_next;
         anim_busy   <= busy_next;
         div         <= div_next;
         act_pend    <= act_pend_next;
         frame_clk_d <= frame_clk;
         tick_arm    <= 1'b1;
      end
   end

   always_comb begin
      state_next    = state;
      div_next      = div;
      sel_next      = sel;
      x_next        = shape_x;
      busy_next     = anim_busy;
      act_pend_next = act_pend;
      target        = IDLE;

      if (act_req && state != ACTION) act_pend_next = 1'b1;

      if (state == ACTION || act_pend) target = ACTION;
      else if (dir == 2'b01)           target = WALK_R;
      else if (dir == 2'b10)           target = WALK_L;
      else                             target = IDLE;

      if (tick) begin
         if (target != state) begin
            state_next = target;
            sel_next   = {target, 2'b00};
            div_next   = '0;
            busy_next  = (target == ACTION);
            if (target == ACTION) act_pend_next = 1'b0;
         end else begin
            if (div == DIV_LAST) begin
               div_next = '0;
               // Only the action row reaches frame 15; its last advance ends the sequence.
               if (sel == 4'd15) begin
                  state_next = IDLE;
                  sel_next   = 4'd0;
                  busy_next  = 1'b0;
               end else begin
                  sel_next = {sel[3:2], sel[1:0] + 2'd1};
               end
            end else begin
               div_next = div + DIV_W'(1);
            end

            if (state == WALK_R) begin
               x_next = (x_inc > X_RIGHT) ? X_RIGHT[9:0] : x_inc[9:0];
            end else if (state == WALK_L) begin
               x_next = (x_wide < X_LEFT + STEP_W) ? X_LEFT[9:0] : shape_x - STEP_N;
            end
         end
      end

      y_next = (sel_next == 4'd13 || sel_next == 4'd14) ? Y_HOP : Y_REST;
   end

endmodule

// File: tb/tb_sprite_sequencer.sv
// Bench for sprite_sequencer: tick-count reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_sprite_sequencer;

   localparam int FRAME_DIV = 8;
   localparam int STEP      = 2;
   localparam int X_MIN     = 0;
   localparam int X_MAX     = 640;
   localparam int X_INIT    = 304;
   localparam int Y_INIT    = 400;
   localparam int HOP       = 8;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b1;
   logic       frame_clk = 1'b0;
   logic [1:0] dir = 2'b00;
   logic       act_req = 1'b0;
   logic [3:0] sel, sel_b;
   logic [9:0] shape_x, shape_y, shape_x_b, shape_y_b;
   logic       anim_busy, anim_busy_b;
   logic [1:0] state_dbg, state_dbg_b;

   int vectors = 0;
   int miscompares = 0;
   bit cmp_en = 1'b0;

   sprite_sequencer #(
      .FRAME_DIV(FRAME_DIV), .STEP(STEP), .X_MIN(X_MIN), .X_MAX(X_MAX),
      .X_INIT(X_INIT), .Y_INIT(Y_INIT), .HOP(HOP)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .dir(dir), .act_req(act_req),
      .sel(sel), .shape_x(shape_x), .shape_y(shape_y), .anim_busy(anim_busy),
      .state_dbg(state_dbg)
   );

   // Odd start position so a left walk reaches x=1 before clamping.
   sprite_sequencer #(
      .FRAME_DIV(FRAME_DIV), .STEP(STEP), .X_MIN(X_MIN), .X_MAX(X_MAX),
      .X_INIT(7), .Y_INIT(Y_INIT), .HOP(HOP)
   ) dut_b (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .dir(dir), .act_req(act_req),
      .sel(sel_b), .shape_x(shape_x_b), .shape_y(shape_y_b), .anim_busy(anim_busy_b),
      .state_dbg(state_dbg_b)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: row of the sheet, ticks spent in that row, position.
   typedef struct {
      int row;
      int n;
      int x;
      bit pend;
      bit fcd;
      bit armed;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.row = 0; r.n = 0; r.x = X_INIT; r.pend = 0; r.fcd = 0; r.armed = 0;
      return r;
   endfunction

   function automatic model_t model_step(model_t cur, bit fc, logic [1:0] d, bit ar);
      model_t r;
      int     tgt;
      bit     entering;
      r = cur;
      entering = 0;
      r.fcd = fc;
      r.armed = 1;
      if (fc && !cur.fcd && cur.armed) begin
         if (cur.row == 3) begin
            if (cur.n + 1 == 4 * FRAME_DIV) begin
               r.row = 0; r.n = 0;
            end else begin
               r.n = cur.n + 1;
            end
         end else begin
            tgt = cur.pend ? 3 : (d == 2'b01) ? 1 : (d == 2'b10) ? 2 : 0;
            if (tgt != cur.row) begin
               r.row = tgt; r.n = 0;
               if (tgt == 3) begin r.pend = 0; entering = 1; end
            end else begin
               r.n = cur.n + 1;
               if (cur.row == 1) r.x = (cur.x + STEP > X_MAX - 32) ? X_MAX - 32 : cur.x + STEP;
               if (cur.row == 2) r.x = (cur.x < X_MIN + STEP) ? X_MIN : cur.x - STEP;
            end
         end
      end
      if (ar && cur.row != 3 && !entering) r.pend = 1;
      return r;
   endfunction

   function automatic int exp_sel(model_t cur);
      return cur.row * 4 + (cur.n / FRAME_DIV) % 4;
   endfunction

   function automatic int exp_y(model_t cur);
      int s;
      s = exp_sel(cur);
      return (s == 13 || s == 14) ? Y_INIT - HOP : Y_INIT;
   endfunction

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) m <= model_reset();
      else          m <= model_step(m, frame_clk, dir, act_req);
   end

   always @(negedge Clk) begin
      if (cmp_en) begin
         check("sel", int'(sel), exp_sel(m));
         check("shape_x", int'(shape_x), m.x);
         check("shape_y", int'(shape_y), exp_y(m));
         check("anim_busy", int'(anim_busy), int'(m.row == 3));
      end
   end

   task automatic do_ticks(input int count);
      repeat (count) begin
         @(posedge Clk); #1 frame_clk = 1'b1;
         @(posedge Clk);
         @(posedge Clk); #1 frame_clk = 1'b0;
         @(posedge Clk);
         @(posedge Clk); #1;
      end
   endtask

   task automatic pulse_act();
      @(posedge Clk); #1 act_req = 1'b1;
      @(posedge Clk); #1 act_req = 1'b0;
   endtask

   task automatic apply_reset();
      @(posedge Clk); #1 Reset_n = 1'b0;
      frame_clk = 1'b0; act_req = 1'b0; dir = 2'b00;
      @(posedge Clk);
      @(posedge Clk); #1 Reset_n = 1'b1;
   endtask

   initial begin
      #1 Reset_n = 1'b0;
      @(posedge Clk);
      @(posedge Clk); #1;
      cmp_en = 1'b1;
      check("rst_sel", int'(sel), 0);
      check("rst_x", int'(shape_x), 304);
      check("rst_y", int'(shape_y), 400);
      check("rst_busy", int'(anim_busy), 0);
      @(posedge Clk); #1 Reset_n = 1'b1;

      // Idle cycling: frame advances every 8 ticks, wrapping after 3.
      dir = 2'b00;
      do_ticks(8);  check("idle_t8", int'(sel), 1);
      do_ticks(8);  check("idle_t16", int'(sel), 2);
      do_ticks(4);  check("idle_t20", int'(sel), 2); check("idle_x", int'(shape_x), 304);
      do_ticks(12); check("idle_wrap", int'(sel), 0);

      // Walk right from reset, then async reset mid-walk.
      apply_reset();
      dir = 2'b01;
      do_ticks(1);  check("wr_entry_sel", int'(sel), 4); check("wr_entry_x", int'(shape_x), 304);
      do_ticks(8);  check("wr_t8_sel", int'(sel), 5); check("wr_t8_x", int'(shape_x), 320);
      do_ticks(2);  check("wr_t10_x", int'(shape_x), 324);
      do_ticks(13); check("wr_t23_sel", int'(sel), 6); check("wr_t23_x", int'(shape_x), 350);
      #2 Reset_n = 1'b0;
      #1;
      check("async_sel", int'(sel), 0);
      check("async_x", int'(shape_x), 304);
      check("async_busy", int'(anim_busy), 0);
      frame_clk = 1'b1;
      @(posedge Clk);
      @(posedge Clk); #1 Reset_n = 1'b1;
      repeat (4) @(posedge Clk);
      #1 check("held_fc_no_tick", int'(sel), 0);
      frame_clk = 1'b0;
      do_ticks(1);  check("post_rst_tick", int'(sel), 4);

      // Right edge clamp, then left walk to the left edge.
      apply_reset();
      dir = 2'b01;
      do_ticks(1);
      do_ticks(151); check("near_right", int'(shape_x), 606);
      do_ticks(1);   check("clamp_r1", int'(shape_x), 608);
      do_ticks(1);   check("clamp_r2", int'(shape_x), 608);
      do_ticks(1);   check("clamp_r3", int'(shape_x), 608);
      dir = 2'b10;
      do_ticks(1);   check("wl_entry_sel", int'(sel), 8); check("wl_entry_x", int'(shape_x), 608);
      do_ticks(304); check("left_zero", int'(shape_x), 0);
      do_ticks(2);   check("clamp_l", int'(shape_x), 0);

      // Odd-position instance: 7 -> 5 -> 3 -> 1 -> 0 -> 0.
      apply_reset();
      dir = 2'b10;
      do_ticks(1); check("b_entry_sel", int'(sel_b), 8); check("b_entry_x", int'(shape_x_b), 7);
      do_ticks(1); check("b_x5", int'(shape_x_b), 5);
      do_ticks(1); check("b_x3", int'(shape_x_b), 3);
      do_ticks(1); check("b_x1", int'(shape_x_b), 1);
      do_ticks(1); check("b_x0", int'(shape_x_b), 0);
      do_ticks(1); check("b_x0_hold", int'(shape_x_b), 0);

      // Action requested between ticks while walking right.
      apply_reset();
      dir = 2'b01;
      do_ticks(3);
      pulse_act();
      do_ticks(1); check("act_sel", int'(sel), 12); check("act_busy", int'(anim_busy), 1);
                   check("act_y", int'(shape_y), 400); check("act_x", int'(shape_x), 308);
      do_ticks(8); check("act13_sel", int'(sel), 13); check("act13_y", int'(shape_y), 392);
      do_ticks(8); check("act14_sel", int'(sel), 14); check("act14_y", int'(shape_y), 392);
      do_ticks(8); check("act15_sel", int'(sel), 15); check("act15_y", int'(shape_y), 400);
      do_ticks(8); check("act_end_sel", int'(sel), 0); check("act_end_busy", int'(anim_busy), 0);
                   check("act_end_x", int'(shape_x), 308);
      do_ticks(1); check("act_resume_walk", int'(sel), 4);

      // Action is not restarted by act_req nor interrupted by dir.
      apply_reset();
      pulse_act();
      do_ticks(1); check("act2_sel", int'(sel), 12);
      for (int i = 0; i < 31; i++) begin
         dir = (i % 3 == 0) ? 2'b01 : (i % 3 == 1) ? 2'b10 : 2'b00;
         if (i % 5 == 0) pulse_act();
         do_ticks(1);
      end
      check("act2_t31_sel", int'(sel), 15);
      check("act2_x", int'(shape_x), 304);
      dir = 2'b00;
      do_ticks(1); check("act2_end_sel", int'(sel), 0); check("act2_end_busy", int'(anim_busy), 0);
      do_ticks(1); check("act2_no_relatch", int'(anim_busy), 0); check("act2_idle_sel", int'(sel), 0);

      @(negedge Clk);
      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
